// File: rtl/mult_error_monitor_if.sv
// Sample stream and statistics bundle between a stimulus source and mult_error_monitor.
// The master drives samples and start; the slave (the monitor) returns status and statistics.
interface mult_error_monitor_if #(
    parameter int PW           = 8,
    parameter int LOG2_SAMPLES = 8
);
    logic                           start;
    logic                           in_valid;
    logic [PW-1:0]                  approx_product;
    logic [PW-1:0]                  exact_product;
    logic                           in_ready;
    logic                           busy;
    logic                           done;
    logic [LOG2_SAMPLES:0]          err_count;
    logic [PW+LOG2_SAMPLES-1:0]     sum_abs_err;
    logic [PW+LOG2_SAMPLES:0]       sum_signed_err;
    logic [PW-1:0]                  max_abs_err;
    logic [LOG2_SAMPLES-1:0]        max_err_index;
    logic [PW-1:0]                  mean_abs_err;

    modport master (
        output start, in_valid, approx_product, exact_product,
        input  in_ready, busy, done, err_count, sum_abs_err, sum_signed_err,
               max_abs_err, max_err_index, mean_abs_err
    );

    modport slave (
        input  start, in_valid, approx_product, exact_product,
        output in_ready, busy, done, err_count, sum_abs_err, sum_signed_err,
               max_abs_err, max_err_index, mean_abs_err
    );
endinterface

// File: rtl/mult_error_monitor.sv
// Error-statistics monitor for an approximate multiplier: accumulates error count, sums and
// the first-occurring maximum error over a 2^LOG2_SAMPLES sample window, then holds them.
//
// state | meaning
// IDLE  | after reset; waiting for start, samples ignored
// RUN   | accepting one sample per in_valid cycle
// DONE  | window complete; statistics held until the next start
module mult_error_monitor #(
    parameter int PW           = 8,
    parameter int LOG2_SAMPLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    mult_error_monitor_if.slave mon
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [LOG2_SAMPLES-1:0]    sample_idx;
    logic [LOG2_SAMPLES:0]      err_count_q;
    logic [PW+LOG2_SAMPLES-1:0] sum_abs_q;
    logic [PW+LOG2_SAMPLES:0]   sum_signed_q;
    logic [PW-1:0]              max_abs_q;
    logic [LOG2_SAMPLES-1:0]    max_idx_q;

    logic                       accept;
    logic                       clear;
    logic                       last_sample;
    logic signed [PW:0]         diff;
    logic signed [PW:0]         diff_neg;
    logic [PW-1:0]              abs_diff;

    assign accept      = (state_q == RUN) && mon.in_valid;
    assign clear       = mon.start && (state_q != RUN);
    assign last_sample = &sample_idx;

    // PW+1 signed bits hold any difference of two PW-bit unsigned values; |d| fits in PW bits.
    assign diff     = $signed({1'b0, mon.approx_product}) - $signed({1'b0, mon.exact_product});
    assign diff_neg = -diff;
    assign abs_diff = diff[PW] ? diff_neg[PW-1:0] : diff[PW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (mon.start) state_d = RUN;
            RUN:     if (accept && last_sample) state_d = DONE;
            DONE:    if (mon.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mon.busy     = 1'b0;
        mon.in_ready = 1'b0;
        mon.done     = 1'b0;
        case (state_q)
            RUN: begin
                mon.busy     = 1'b1;
                mon.in_ready = 1'b1;
            end
            DONE:    mon.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sample_idx   <= '0;
            err_count_q  <= '0;
            sum_abs_q    <= '0;
            sum_signed_q <= '0;
            max_abs_q    <= '0;
            max_idx_q    <= '0;
        end else if (accept) begin
            sample_idx   <= sample_idx + 1'b1;
            err_count_q  <= err_count_q + {{LOG2_SAMPLES{1'b0}}, (diff != '0)};
            sum_abs_q    <= sum_abs_q + {{LOG2_SAMPLES{1'b0}}, abs_diff};
            sum_signed_q <= sum_signed_q + {{LOG2_SAMPLES{diff[PW]}}, diff};
            // Strict compare so a tie keeps the earliest index.
            if (abs_diff > max_abs_q) begin
                max_abs_q <= abs_diff;
                max_idx_q <= sample_idx;
            end
        end
    end

    assign mon.err_count      = err_count_q;
    assign mon.sum_abs_err    = sum_abs_q;
    assign mon.sum_signed_err = sum_signed_q;
    assign mon.max_abs_err    = max_abs_q;
    assign mon.max_err_index  = max_idx_q;
    assign mon.mean_abs_err   = sum_abs_q[PW+LOG2_SAMPLES-1:LOG2_SAMPLES];
endmodule

// File: tb/tb_mult_error_monitor.sv
// Randomised and directed windows for mult_error_monitor, checked against a plain-arithmetic
// reference of the error statistics.
module tb_mult_error_monitor;
    localparam int PW  = 8;
    localparam int L2  = 8;
    localparam int N   = 1 << L2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    int   ap [N];
    int   ex [N];
    longint e_cnt, e_sabs, e_ssgn, e_max, e_idx;

    mult_error_monitor_if #(.PW(PW), .LOG2_SAMPLES(L2)) mon ();

    mult_error_monitor #(.PW(PW), .LOG2_SAMPLES(L2)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode: 0 exact, 1 single error at 37, 2 offset +2, 3 approx=0, 4 random approx
    task automatic fill(input int mode);
        for (int i = 0; i < N; i++) begin
            int a, b;
            a = i / 16;
            b = i % 16;
            ex[i] = a * b;
            case (mode)
                0: ap[i] = ex[i];
                1: ap[i] = (i == 37) ? ex[i] - 6 : ex[i];
                2: ap[i] = (ex[i] + 2 > 255) ? 255 : ex[i] + 2;
                3: ap[i] = 0;
                default: ap[i] = $urandom_range(0, 255);
            endcase
        end
        if (mode == 1 && ex[37] < 6) ex[37] = ex[37] + 6;  // keep approx non-negative
        if (mode == 1) ap[37] = ex[37] - 6;
    endtask

    task automatic model();
        e_cnt = 0; e_sabs = 0; e_ssgn = 0; e_max = 0; e_idx = 0;
        for (int i = 0; i < N; i++) begin
            longint d, m;
            d = longint'(ap[i]) - longint'(ex[i]);
            m = (d < 0) ? -d : d;
            if (d != 0) e_cnt++;
            e_sabs += m;
            e_ssgn += d;
            if (m > e_max) begin
                e_max = m;
                e_idx = i;
            end
        end
    endtask

    task automatic check_stats(input string tag);
        check({tag, ".err_count"}, longint'(mon.err_count), e_cnt);
        check({tag, ".sum_abs"}, longint'(mon.sum_abs_err), e_sabs);
        check({tag, ".sum_signed"}, longint'($signed(mon.sum_signed_err)), e_ssgn);
        check({tag, ".max_abs"}, longint'(mon.max_abs_err), e_max);
        check({tag, ".max_idx"}, longint'(mon.max_err_index), e_idx);
        check({tag, ".mean"}, longint'(mon.mean_abs_err), e_sabs / N);
    endtask

    // Drives start then all samples of the current arrays; inputs change on negedge.
    task automatic run_window(input string tag, input bit bubbles, input bit random_gaps);
        mon.start = 1'b1;
        @(negedge clk);
        mon.start = 1'b0;
        check({tag, ".busy_rise"}, longint'(mon.busy), 1);
        check({tag, ".done_drop"}, longint'(mon.done), 0);
        for (int i = 0; i < N; i++) begin
            if (bubbles || (random_gaps && $urandom_range(0, 3) == 0)) begin
                mon.in_valid = 1'b0;
                mon.approx_product = 8'hFF;
                mon.exact_product  = 8'h00;
                if (bubbles && (i == 50 || i == 200)) mon.start = 1'b1;
                @(negedge clk);
                mon.start = 1'b0;
            end
            mon.in_valid       = 1'b1;
            mon.approx_product = ap[i][PW-1:0];
            mon.exact_product  = ex[i][PW-1:0];
            if (i == N - 1) begin
                check({tag, ".busy_last"}, longint'(mon.busy), 1);
                check({tag, ".done_early"}, longint'(mon.done), 0);
            end
            @(negedge clk);
        end
        mon.in_valid = 1'b0;
        check({tag, ".done"}, longint'(mon.done), 1);
        check({tag, ".busy_off"}, longint'(mon.busy), 0);
        model();
        check_stats(tag);
        // Samples offered in DONE must not disturb the held results.
        mon.in_valid = 1'b1;
        mon.approx_product = 8'hFF;
        mon.exact_product  = 8'h00;
        repeat (3) @(negedge clk);
        mon.in_valid = 1'b0;
        check_stats({tag, ".hold"});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        mon.start = 1'b0;
        mon.in_valid = 1'b0;
        mon.approx_product = '0;
        mon.exact_product  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.busy", longint'(mon.busy), 0);
        check("reset.done", longint'(mon.done), 0);
        check("reset.in_ready", longint'(mon.in_ready), 0);
        check("reset.stats", longint'(mon.err_count) + longint'(mon.sum_abs_err)
              + longint'(mon.sum_signed_err) + longint'(mon.max_abs_err), 0);

        // IDLE ignores samples
        mon.in_valid = 1'b1;
        mon.approx_product = 8'd9;
        @(negedge clk);
        mon.in_valid = 1'b0;
        check("idle.ignore", longint'(mon.sum_abs_err), 0);

        fill(0);
        run_window("exact", 1'b0, 1'b0);
        check("exact.err0", longint'(mon.err_count), 0);

        fill(1);
        run_window("single", 1'b0, 1'b0);
        check("single.idx37", longint'(mon.max_err_index), 37);
        check("single.sgn", longint'($signed(mon.sum_signed_err)), -6);

        fill(2);
        run_window("offset", 1'b0, 1'b0);
        check("offset.max2", longint'(mon.max_abs_err), 2);
        check("offset.idx0", longint'(mon.max_err_index), 0);
        check("offset.cnt", longint'(mon.err_count), 256);

        fill(4);
        run_window("gapfree", 1'b0, 1'b0);
        run_window("bubbles", 1'b1, 1'b0);

        // Reset mid-window discards the partial window.
        fill(4);
        mon.start = 1'b1;
        @(negedge clk);
        mon.start = 1'b0;
        for (int i = 0; i < 101; i++) begin
            mon.in_valid = 1'b1;
            mon.approx_product = ap[i][PW-1:0];
            mon.exact_product  = ex[i][PW-1:0];
            @(negedge clk);
        end
        mon.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", longint'(mon.busy), 0);
        check("midrst.ready", longint'(mon.in_ready), 0);
        check("midrst.done", longint'(mon.done), 0);
        check("midrst.stats", longint'(mon.err_count) + longint'(mon.sum_abs_err)
              + longint'(mon.sum_signed_err) + longint'(mon.max_abs_err)
              + longint'(mon.max_err_index), 0);
        fill(1);
        run_window("after_rst", 1'b0, 1'b0);
        check("after_rst.cnt1", longint'(mon.err_count), 1);

        // Back-to-back from DONE.
        fill(3);
        run_window("zero", 1'b0, 1'b0);
        check("zero.sum", longint'(mon.sum_abs_err), 14400);
        check("zero.mean", longint'(mon.mean_abs_err), 56);
        check("zero.sgn", longint'($signed(mon.sum_signed_err)), -14400);
        check("zero.max", longint'(mon.max_abs_err), 225);
        check("zero.idx", longint'(mon.max_err_index), 255);
        check("zero.cnt", longint'(mon.err_count), 225);

        for (int r = 0; r < 3; r++) begin
            fill(4);
            run_window("rand", 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end
endmodule
